// File: rtl/imu_poll_sequencer_pkg.sv
// Shared types and constants for the IMU poll sequencer: FSM state encoding,
// default sensor command bytes, burst length and little-endian word helper.
package imu_poll_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_G_WAIT = 3'd1,
      ST_G_RD   = 3'd2,
      ST_A_WAIT = 3'd3,
      ST_A_RD   = 3'd4,
      ST_PUB    = 3'd5
   } imu_state_e;

   localparam logic [7:0] GYRO_ADDR_DEF = 8'hE8;
   localparam logic [7:0] ACCL_ADDR_DEF = 8'hF2;
   localparam logic [2:0] READ_LEN      = 3'd7;
   localparam int         AXIS_BYTES    = 6;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } axis3_t;

   function automatic logic signed [15:0] le_word(input logic [7:0] lo, input logic [7:0] hi);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/imu_poll_sequencer_if.sv
// Handshake bundle between the poll sequencer and spi_interface.
interface imu_poll_sequencer_if;
   logic       spi_sensor_select;
   logic       spi_write_start;
   logic [7:0] spi_write_data;
   logic [2:0] spi_write_count_bytes;
   logic       spi_write_ready;
   logic       spi_read_ready;
   logic [7:0] spi_read_data;

   modport master (
      output spi_sensor_select, spi_write_start, spi_write_data, spi_write_count_bytes,
      input  spi_write_ready, spi_read_ready, spi_read_data
   );

   modport slave (
      input  spi_sensor_select, spi_write_start, spi_write_data, spi_write_count_bytes,
      output spi_write_ready, spi_read_ready, spi_read_data
   );
endinterface

// File: rtl/imu_poll_sequencer_axis_assembler.sv
// Six-byte indexed capture register shared by both sensors; presents the three
// little-endian signed axes including the byte being loaded this cycle.
module imu_axis_assembler
   import imu_poll_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] data,
   output logic       done,
   output axis3_t     axes
);

   logic [AXIS_BYTES-1:0][7:0] bytes_r;
   logic [AXIS_BYTES-1:0][7:0] bytes_s;
   logic [2:0]                 cnt_r;

   // Next byte image; axes read from it so the final byte is usable on its strobe cycle
   always_comb begin
      for (int i = 0; i < AXIS_BYTES; i++) begin
         if (clear) begin
            bytes_s[i] = 8'h00;
         end else if (load && (cnt_r == 3'(i))) begin
            bytes_s[i] = data;
         end else begin
            bytes_s[i] = bytes_r[i];
         end
      end
      done   = load && (cnt_r == 3'(AXIS_BYTES - 1));
      axes.x = le_word(bytes_s[0], bytes_s[1]);
      axes.y = le_word(bytes_s[2], bytes_s[3]);
      axes.z = le_word(bytes_s[4], bytes_s[5]);
   end

   // Byte storage and write index
   always_ff @(posedge clk) begin
      if (reset) begin
         bytes_r <= '0;
         cnt_r   <= 3'd0;
      end else begin
         bytes_r <= bytes_s;
         if (clear) begin
            cnt_r <= 3'd0;
         end else if (load && (cnt_r < 3'(AXIS_BYTES))) begin
            cnt_r <= cnt_r + 3'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

endmodule

// File: rtl/imu_poll_sequencer.sv
// Periodic gyro-then-accel burst reader for spi_interface; publishes all six
// axes together, with overrun and watchdog reporting.
module imu_poll_sequencer
   import imu_poll_sequencer_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV  = 1000,
   parameter int unsigned TIMEOUT_CYC = 512,
   parameter logic [7:0]  GYRO_ADDR   = GYRO_ADDR_DEF,
   parameter logic [7:0]  ACCL_ADDR   = ACCL_ADDR_DEF
) (
   input  logic                 div_clk,
   input  logic                 reset,
   input  logic                 enable,
   imu_poll_sequencer_if.master spi,
   output logic signed [15:0]   gyro_x,
   output logic signed [15:0]   gyro_y,
   output logic signed [15:0]   gyro_z,
   output logic signed [15:0]   accel_x,
   output logic signed [15:0]   accel_y,
   output logic signed [15:0]   accel_z,
   output logic                 sample_valid,
   output logic                 overrun,
   output logic                 timeout_err,
   output logic                 busy
);

   localparam int              TMR_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int              WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_DIV - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 2);

   imu_state_e       state_r;
   logic [TMR_W-1:0] timer_r;
   logic [WD_W-1:0]  wd_r;
   logic             sel_r;
   logic [7:0]       data_r;
   logic [2:0]       count_r;
   axis3_t           gyro_sh_r;
   axis3_t           gyro_r;
   axis3_t           accel_r;
   logic             sample_valid_r;
   logic             overrun_r;
   logic             timeout_err_r;
   logic             busy_r;

   logic             tick_s;
   logic             in_wait_s;
   logic             in_rd_s;
   logic             start_s;
   logic             asm_load_s;
   logic             asm_done_s;
   axis3_t           asm_axes_s;

   // Sample-rate timer, held at zero while disabled
   always_ff @(posedge div_clk) begin
      if (reset) begin
         timer_r <= '0;
      end else if (!enable) begin
         timer_r <= '0;
      end else if (timer_r == TMR_LAST) begin
         timer_r <= '0;
      end else begin
         timer_r <= timer_r + TMR_W'(1);
      end
   end

   // Start is gated by write_ready directly so it can never assert while the interface is busy
   always_comb begin
      tick_s     = enable && (timer_r == TMR_LAST);
      in_wait_s  = (state_r == ST_G_WAIT) || (state_r == ST_A_WAIT);
      in_rd_s    = (state_r == ST_G_RD) || (state_r == ST_A_RD);
      start_s    = in_wait_s && spi.spi_write_ready;
      asm_load_s = in_rd_s && spi.spi_read_ready;
   end

   imu_axis_assembler u_asm (
      .clk   (div_clk),
      .reset (reset),
      .clear (start_s),
      .load  (asm_load_s),
      .data  (spi.spi_read_data),
      .done  (asm_done_s),
      .axes  (asm_axes_s)
   );

   // Sequencer FSM with registered command, status and axis outputs
   always_ff @(posedge div_clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         wd_r           <= '0;
         sel_r          <= 1'b0;
         data_r         <= 8'h00;
         count_r        <= 3'd0;
         gyro_sh_r      <= '0;
         gyro_r         <= '0;
         accel_r        <= '0;
         sample_valid_r <= 1'b0;
         overrun_r      <= 1'b0;
         timeout_err_r  <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         sample_valid_r <= 1'b0;
         timeout_err_r  <= 1'b0;
         overrun_r      <= tick_s && (state_r != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (tick_s) begin
                  state_r <= ST_G_WAIT;
                  sel_r   <= 1'b0;
                  data_r  <= GYRO_ADDR;
                  count_r <= READ_LEN;
                  busy_r  <= 1'b1;
               end
            end
            ST_G_WAIT, ST_A_WAIT: begin
               if (start_s) begin
                  state_r <= (state_r == ST_G_WAIT) ? ST_G_RD : ST_A_RD;
                  wd_r    <= '0;
               end
            end
            ST_G_RD, ST_A_RD: begin
               // A final byte arriving on the expiry cycle still counts as success
               if (asm_done_s && (state_r == ST_G_RD)) begin
                  state_r   <= ST_A_WAIT;
                  sel_r     <= 1'b1;
                  data_r    <= ACCL_ADDR;
                  gyro_sh_r <= asm_axes_s;
               end else if (asm_done_s) begin
                  state_r        <= ST_PUB;
                  gyro_r         <= gyro_sh_r;
                  accel_r        <= asm_axes_s;
                  sample_valid_r <= 1'b1;
               end else if (wd_r == WD_LAST) begin
                  state_r       <= ST_IDLE;
                  timeout_err_r <= 1'b1;
                  busy_r        <= 1'b0;
               end else begin
                  wd_r <= wd_r + WD_W'(1);
               end
            end
            ST_PUB: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign spi.spi_sensor_select     = sel_r;
   assign spi.spi_write_start       = start_s;
   assign spi.spi_write_data        = data_r;
   assign spi.spi_write_count_bytes = count_r;

   assign gyro_x       = gyro_r.x;
   assign gyro_y       = gyro_r.y;
   assign gyro_z       = gyro_r.z;
   assign accel_x      = accel_r.x;
   assign accel_y      = accel_r.y;
   assign accel_z      = accel_r.z;
   assign sample_valid = sample_valid_r;
   assign overrun      = overrun_r;
   assign timeout_err  = timeout_err_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_imu_poll_sequencer.sv
// Bench for imu_poll_sequencer: behavioural SPI slave, table vectors, random
// samples against an arithmetic model, and timeout/overrun/reset sequences.
module tb_imu_poll_sequencer;
   import imu_poll_sequencer_pkg::*;

   localparam int DIV = 100;
   localparam int TMO = 64;

   typedef logic [7:0] bytes6_t [6];
   typedef int exp6_t [6];
   typedef struct {
      bytes6_t g;
      bytes6_t a;
      exp6_t   e;
      int      gap;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic signed [15:0] gyro_x, gyro_y, gyro_z, accel_x, accel_y, accel_z;
   logic sample_valid, overrun, timeout_err, busy;

   imu_poll_sequencer_if bus ();

   imu_poll_sequencer #(
      .SAMPLE_DIV  (DIV),
      .TIMEOUT_CYC (TMO),
      .GYRO_ADDR   (8'hE8),
      .ACCL_ADDR   (8'hF2)
   ) dut (
      .div_clk      (clk),
      .reset        (reset),
      .enable       (enable),
      .spi          (bus),
      .gyro_x       (gyro_x),
      .gyro_y       (gyro_y),
      .gyro_z       (gyro_z),
      .accel_x      (accel_x),
      .accel_y      (accel_y),
      .accel_z      (accel_z),
      .sample_valid (sample_valid),
      .overrun      (overrun),
      .timeout_err  (timeout_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle_no = 0;
   int start_cnt = 0;
   int bad_start = 0;
   int ovr_cnt = 0;
   exp6_t last_e = '{0, 0, 0, 0, 0, 0};

   always @(posedge clk) cycle_no <= cycle_no + 1;

   always @(negedge clk) begin
      if (bus.spi_write_start) start_cnt <= start_cnt + 1;
      if (bus.spi_write_start && !bus.spi_write_ready) bad_start <= bad_start + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   function automatic int axis_val(input logic [7:0] lo, input logic [7:0] hi);
      int v;
      v = int'(hi) * 256 + int'(lo);
      if (v >= 32768) v = v - 65536;
      return v;
   endfunction

   task automatic check_axes(input string tag, input exp6_t e);
      check({tag, "_gyro_x"}, int'(gyro_x), e[0]);
      check({tag, "_gyro_y"}, int'(gyro_y), e[1]);
      check({tag, "_gyro_z"}, int'(gyro_z), e[2]);
      check({tag, "_accel_x"}, int'(accel_x), e[3]);
      check({tag, "_accel_y"}, int'(accel_y), e[4]);
      check({tag, "_accel_z"}, int'(accel_z), e[5]);
   endtask

   // SPI slave: wait for start, verify command, then return nbytes bytes
   task automatic do_txn(input bit sel, input bytes6_t b, input int gap, input int nbytes,
                         output int st_cyc);
      bit seen;
      seen = 1'b0;
      st_cyc = -1;
      for (int i = 0; i < 3 * DIV && !seen; i++) begin
         smp();
         if (bus.spi_write_start) begin
            seen = 1'b1;
            st_cyc = cycle_no;
         end
      end
      check("start_seen", int'(seen), 1);
      if (seen) begin
         check("start_select", int'(bus.spi_sensor_select), int'(sel));
         check("start_cmd", int'(bus.spi_write_data), sel ? 242 : 232);
         check("start_len", int'(bus.spi_write_count_bytes), 7);
         cyc();
         bus.spi_write_ready = 1'b0;
         for (int j = 0; j < nbytes; j++) begin
            repeat (gap) cyc();
            bus.spi_read_ready = 1'b1;
            bus.spi_read_data  = b[j];
            cyc();
            bus.spi_read_ready = 1'b0;
            bus.spi_read_data  = 8'h00;
         end
         if (nbytes == 6) bus.spi_write_ready = 1'b1;
      end
   endtask

   task automatic run_sample(input string tag, input bytes6_t g, input bytes6_t a, input exp6_t e,
                             input int gap, input bit drop_en, output int g_st);
      int a_st;
      do_txn(1'b0, g, gap, 6, g_st);
      if (drop_en) enable = 1'b0;
      do_txn(1'b1, a, gap, 6, a_st);
      smp();
      check({tag, "_valid"}, int'(sample_valid), 1);
      check_axes(tag, e);
      smp();
      check({tag, "_valid_width"}, int'(sample_valid), 0);
      last_e = e;
   endtask

   vec_t    vt [3];
   bytes6_t g, a;
   exp6_t   e;
   exp6_t   zeros = '{0, 0, 0, 0, 0, 0};
   int      st, a_st, tcyc, sv, s0, o0, rdy_cyc;
   bit      got;

   initial begin
      vt[0].g = '{8'h01, 8'h00, 8'h02, 8'h00, 8'hFF, 8'hFF};
      vt[0].a = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h00, 8'h80};
      vt[0].e = '{1, 2, -1, 16, 32, -32768};
      vt[0].gap = 1;
      vt[1].g = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h34, 8'h12};
      vt[1].a = '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01};
      vt[1].e = '{-32768, 32767, 4660, -2, 0, 257};
      vt[1].gap = 2;
      vt[2].g = '{8'h7F, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h01};
      vt[2].a = '{8'hAA, 8'h55, 8'h55, 8'hAA, 8'h00, 8'h00};
      vt[2].e = '{-129, 128, 256, 21930, -21931, 0};
      vt[2].gap = 0;

      reset = 1'b1;
      enable = 1'b0;
      bus.spi_write_ready = 1'b1;
      bus.spi_read_ready  = 1'b0;
      bus.spi_read_data   = 8'h00;
      repeat (4) cyc();
      smp();
      check_axes("reset", zeros);
      check("reset_valid", int'(sample_valid), 0);
      check("reset_overrun", int'(overrun), 0);
      check("reset_timeout", int'(timeout_err), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_start", int'(bus.spi_write_start), 0);
      check("reset_select", int'(bus.spi_sensor_select), 0);
      check("reset_len", int'(bus.spi_write_count_bytes), 0);
      cyc();
      reset = 1'b0;
      enable = 1'b1;

      for (int i = 0; i < 3; i++) run_sample("table", vt[i].g, vt[i].a, vt[i].e, vt[i].gap, 1'b0, st);

      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < 6; k++) begin
            g[k] = 8'($urandom_range(0, 255));
            a[k] = 8'($urandom_range(0, 255));
         end
         for (int k = 0; k < 3; k++) begin
            e[k]     = axis_val(g[2*k], g[2*k+1]);
            e[k + 3] = axis_val(a[2*k], a[2*k+1]);
         end
         run_sample("random", g, a, e, $urandom_range(0, 4), 1'b0, st);
      end

      // Accel stalls after three bytes: watchdog must fire 64 cycles after its start
      g = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      a = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
      do_txn(1'b0, g, 0, 6, st);
      do_txn(1'b1, a, 1, 3, a_st);
      got = 1'b0;
      tcyc = -1;
      sv = 0;
      for (int i = 0; i < 2 * TMO && !got; i++) begin
         smp();
         if (sample_valid) sv++;
         if (timeout_err) begin
            got = 1'b1;
            tcyc = cycle_no;
         end
      end
      check("timeout_seen", int'(got), 1);
      check("timeout_latency", tcyc - a_st, TMO);
      check("timeout_busy", int'(busy), 0);
      check("timeout_no_valid", sv, 0);
      check_axes("timeout", last_e);
      cyc();
      bus.spi_write_ready = 1'b1;

      // Interface not ready for a long time: no start, one dropped tick, start on first ready cycle
      bus.spi_write_ready = 1'b0;
      for (int i = 0; i < 3 * DIV && !busy; i++) smp();
      check("hold_busy", int'(busy), 1);
      cyc();
      s0 = start_cnt;
      o0 = ovr_cnt;
      repeat (130) cyc();
      check("hold_no_start", start_cnt - s0, 0);
      check("hold_overrun", ovr_cnt - o0, 1);
      bus.spi_write_ready = 1'b1;
      rdy_cyc = cycle_no;
      run_sample("after_hold", vt[0].g, vt[0].a, vt[0].e, 0, 1'b0, st);
      check("start_on_first_ready", st - rdy_cyc, 0);
      run_sample("next_tick", vt[1].g, vt[1].a, vt[1].e, 1, 1'b0, st);

      // Enable drops between gyro and accel: sequence finishes, then no new starts
      run_sample("enable_drop", vt[2].g, vt[2].a, vt[2].e, 1, 1'b1, st);
      cyc();
      s0 = start_cnt;
      repeat (3 * DIV) cyc();
      check("disabled_no_start", start_cnt - s0, 0);
      check("disabled_busy", int'(busy), 0);
      enable = 1'b1;

      // Reset during gyro reads: idle next cycle, outputs cleared, then a clean sample
      g = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00};
      do_txn(1'b0, g, 0, 3, st);
      reset = 1'b1;
      bus.spi_write_ready = 1'b1;
      cyc();
      reset = 1'b0;
      smp();
      check("mid_reset_busy", int'(busy), 0);
      check_axes("mid_reset", zeros);
      last_e = zeros;
      run_sample("post_reset", vt[1].g, vt[1].a, vt[1].e, 0, 1'b0, st);

      cyc();
      check("start_never_without_ready", bad_start, 0);
      check("overrun_total", ovr_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
